// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI read/write request controllers: default widths,
// controller state encoding and burst helper functions.
package axi_ctrl_pkg;

  localparam int unsigned C_WR_LENGTH       = 4096;
  localparam int unsigned C_USER_DATA_WIDTH = 16;
  localparam int unsigned C_AXI_DATA_WIDTH  = 128;
  localparam int unsigned C_AXI_ADDR_WIDTH  = 32;
  localparam int unsigned C_ADDR_MAX_WIDTH  = 64;

  typedef logic [C_ADDR_MAX_WIDTH-1:0] addr_max_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CMD   = 2'd3
  } ctrl_state_e;

  function automatic int unsigned beats_per_burst(input int unsigned len,
                                                  input int unsigned width);
    return len / (width / 8);
  endfunction

  // Next burst start inside [baddr, faddr]; the extra sum bit keeps the carry in the compare.
  function automatic addr_max_t next_burst_addr(input addr_max_t addr, input addr_max_t len,
                                                input addr_max_t baddr, input addr_max_t faddr);
    logic [C_ADDR_MAX_WIDTH:0] sum;
    sum = {1'b0, addr} + {1'b0, len};
    return (sum > {1'b0, faddr}) ? baddr : sum[C_ADDR_MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/axi_wr_ctrl_if.sv
// User word stream plus AXI write-data and write-command channels of axi_wr_ctrl.
interface axi_wr_ctrl_if
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_USER_DATA_WIDTH = C_USER_DATA_WIDTH,
  parameter int unsigned P_AXI_DATA_WIDTH  = C_AXI_DATA_WIDTH,
  parameter int unsigned P_AXI_ADDR_WIDTH  = C_AXI_ADDR_WIDTH
);

  logic [P_USER_DATA_WIDTH-1:0] i_user_data;
  logic                         i_user_valid;
  logic                         o_user_ready;
  logic [P_AXI_DATA_WIDTH-1:0]  o_u2a_wdata;
  logic                         o_u2a_wvalid;
  logic                         o_u2a_wlast;
  logic                         i_axi_wready;
  logic [P_AXI_ADDR_WIDTH-1:0]  o_u2a_addr;
  logic [7:0]                   o_u2a_length;
  logic                         o_u2a_valid;
  logic                         i_axi_ready;

  modport master (
    input  i_user_data, i_user_valid, i_axi_wready, i_axi_ready,
    output o_user_ready, o_u2a_wdata, o_u2a_wvalid, o_u2a_wlast,
           o_u2a_addr, o_u2a_length, o_u2a_valid
  );

  modport slave (
    output i_user_data, i_user_valid, i_axi_wready, i_axi_ready,
    input  o_user_ready, o_u2a_wdata, o_u2a_wvalid, o_u2a_wlast,
           o_u2a_addr, o_u2a_length, o_u2a_valid
  );

endinterface

// File: rtl/axi_wr_packer.sv
// Packs narrow user words into one AXI beat, first word in the MSBs, and holds the
// completed beat in an output register until the data FIFO takes it.
module axi_wr_packer
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_USER_DATA_WIDTH = C_USER_DATA_WIDTH,
  parameter int unsigned P_AXI_DATA_WIDTH  = C_AXI_DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_USER_DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_last,
  output logic                         o_beat_done,
  output logic [P_AXI_DATA_WIDTH-1:0]  o_data,
  output logic                         o_valid,
  output logic                         o_last,
  input  logic                         i_out_ready
);

  localparam int unsigned PACK  = P_AXI_DATA_WIDTH / P_USER_DATA_WIDTH;
  localparam int unsigned CNT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [P_AXI_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [P_AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        accept;

  // The final word may only complete a beat if the output register is free this cycle.
  assign o_ready     = ~((cnt_q == CNT_LAST) & valid_q & ~i_out_ready);
  assign accept      = i_valid & o_ready;
  assign o_beat_done = accept & (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (valid_q && i_out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (accept) begin
      shift_d = {shift_q[P_AXI_DATA_WIDTH-P_USER_DATA_WIDTH-1:0], i_data};
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        data_d  = shift_d;
        valid_d = 1'b1;
        last_d  = i_last;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // NOTE: the shift register is not reset; a cleared word count overwrites it before use.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule

// File: rtl/axi_wr_ctrl.sv
// Write request controller: packs user words into bursts of AXI beats and issues one
// write command per completed burst, walking the address through [baddr, faddr].
module axi_wr_ctrl
  import axi_ctrl_pkg::*;
#(
  parameter int unsigned P_WR_LENGTH       = C_WR_LENGTH,
  parameter int unsigned P_USER_DATA_WIDTH = C_USER_DATA_WIDTH,
  parameter int unsigned P_AXI_DATA_WIDTH  = C_AXI_DATA_WIDTH,
  parameter int unsigned P_AXI_ADDR_WIDTH  = C_AXI_ADDR_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ddr_init,
  input  logic [P_AXI_ADDR_WIDTH-1:0] i_user_baddr,
  input  logic [P_AXI_ADDR_WIDTH-1:0] i_user_faddr,
  axi_wr_ctrl_if.master               bus
);

  localparam int unsigned BEATS  = beats_per_burst(P_WR_LENGTH, P_AXI_DATA_WIDTH);
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [7:0]        LENGTH    = 8'(BEATS - 1);

  logic rst_q1, rst_q2, ddr_q1, ddr_q2;

  ctrl_state_e                 state_q, state_d;
  logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [P_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                        cmd_valid_q, cmd_valid_d;

  logic                        pk_ready, pk_beat_done, pk_valid, pk_last;
  logic [P_AXI_DATA_WIDTH-1:0] pk_data;
  logic                        in_data, wlast_hs;

  always_ff @(posedge i_clk) begin
    rst_q1 <= i_rst;
    rst_q2 <= rst_q1;
    ddr_q1 <= i_ddr_init;
    ddr_q2 <= ddr_q1;
  end

  assign in_data  = (state_q == ST_DATA);
  assign wlast_hs = pk_valid & bus.i_axi_wready & pk_last;

  axi_wr_packer #(
    .P_USER_DATA_WIDTH (P_USER_DATA_WIDTH),
    .P_AXI_DATA_WIDTH  (P_AXI_DATA_WIDTH)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst       (rst_q2),
    .i_data      (bus.i_user_data),
    .i_valid     (bus.i_user_valid & in_data),
    .o_ready     (pk_ready),
    .i_last      (beat_cnt_q == BEAT_LAST),
    .o_beat_done (pk_beat_done),
    .o_data      (pk_data),
    .o_valid     (pk_valid),
    .o_last      (pk_last),
    .i_out_ready (bus.i_axi_wready)
  );

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    if (pk_beat_done) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    if (wlast_hs)     beat_cnt_d = '0;
    unique case (state_q)
      ST_IDLE:  if (ddr_q2) state_d = ST_DATA;
      ST_DATA:  if (pk_beat_done && beat_cnt_q == BEAT_LAST) state_d = ST_DRAIN;
      ST_DRAIN: if (wlast_hs) begin
        state_d     = ST_CMD;
        cmd_valid_d = 1'b1;
      end
      ST_CMD:   if (cmd_valid_q && bus.i_axi_ready) begin
        state_d     = ST_DATA;
        cmd_valid_d = 1'b0;
        addr_d      = P_AXI_ADDR_WIDTH'(next_burst_addr(addr_max_t'(addr_q),
                        addr_max_t'(P_WR_LENGTH), addr_max_t'(i_user_baddr),
                        addr_max_t'(i_user_faddr)));
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst_q2) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      addr_q      <= i_user_baddr;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign bus.o_user_ready = in_data & pk_ready;
  assign bus.o_u2a_wdata  = pk_data;
  assign bus.o_u2a_wvalid = pk_valid;
  assign bus.o_u2a_wlast  = pk_last;
  assign bus.o_u2a_addr   = addr_q;
  assign bus.o_u2a_length = LENGTH;
  assign bus.o_u2a_valid  = cmd_valid_q;

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Bench for axi_wr_ctrl in a 64-byte-burst configuration: a monitor scoreboards every
// word, beat and command against a queue model; directed and table tests drive it.
module tb_axi_wr_ctrl;

  localparam int unsigned LEN   = 64;
  localparam int unsigned UW    = 16;
  localparam int unsigned AW    = 128;
  localparam int unsigned ADW   = 32;
  localparam int unsigned PACK  = AW / UW;
  localparam int unsigned BEATS = LEN / (AW / 8);
  localparam int unsigned WPB   = PACK * BEATS;
  localparam int          BOUND = 2000;

  typedef struct { logic [AW-1:0] data; logic last; } beat_t;
  typedef struct { logic [ADW-1:0] addr; logic [7:0] len; int stalls; } cmd_t;
  typedef struct { logic [31:0] baddr; logic [31:0] faddr; logic [3:0][31:0] exp_addr; } wrap_vec_t;

  logic        clk = 1'b0;
  logic        rst, ddr_init;
  logic [31:0] baddr, faddr;

  axi_wr_ctrl_if #(.P_USER_DATA_WIDTH(UW), .P_AXI_DATA_WIDTH(AW), .P_AXI_ADDR_WIDTH(ADW)) bus ();

  axi_wr_ctrl #(
    .P_WR_LENGTH(LEN), .P_USER_DATA_WIDTH(UW), .P_AXI_DATA_WIDTH(AW), .P_AXI_ADDR_WIDTH(ADW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ddr_init(ddr_init),
    .i_user_baddr(baddr), .i_user_faddr(faddr), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [UW-1:0]   word_q[$];
  beat_t           beat_log[$];
  cmd_t            cmd_log[$];
  longint unsigned m_addr, m_baddr, m_faddr;
  int              words_in_burst, beat_idx, beats_since_cmd, cmd_stalls;
  bit              stall_prev, cstall_prev, mon_en;
  logic [AW-1:0]   prev_wdata;
  logic [ADW-1:0]  prev_caddr;

  task automatic sb_clear(input logic [31:0] b, input logic [31:0] f);
    word_q.delete(); beat_log.delete(); cmd_log.delete();
    m_addr = b; m_baddr = b; m_faddr = f;
    words_in_burst = 0; beat_idx = 0; beats_since_cmd = 0; cmd_stalls = 0;
    stall_prev = 0; cstall_prev = 0;
  endtask

  task automatic monitor_cycle();
    logic [AW-1:0] exp;
    if (stall_prev) begin
      check("wdata_stable", bus.o_u2a_wdata, prev_wdata);
      check("wvalid_held", bus.o_u2a_wvalid, 1);
    end
    if (cstall_prev) begin
      check("cmd_valid_held", bus.o_u2a_valid, 1);
      check("cmd_addr_stable", bus.o_u2a_addr, prev_caddr);
    end
    stall_prev  = bus.o_u2a_wvalid & ~bus.i_axi_wready;
    prev_wdata  = bus.o_u2a_wdata;
    cstall_prev = bus.o_u2a_valid & ~bus.i_axi_ready;
    prev_caddr  = bus.o_u2a_addr;

    if (words_in_burst == WPB) check("ready_low_after_burst", bus.o_user_ready, 0);
    if (bus.i_user_valid && bus.o_user_ready) begin
      word_q.push_back(bus.i_user_data);
      words_in_burst++;
    end
    if (bus.o_u2a_wvalid && bus.i_axi_wready) begin
      exp = '0;
      if (word_q.size() < PACK) check("beat_without_words", word_q.size(), PACK);
      else for (int i = 0; i < PACK; i++) exp[AW-1-UW*i -: UW] = word_q.pop_front();
      check("beat_data", bus.o_u2a_wdata, exp);
      check("beat_last", bus.o_u2a_wlast, beat_idx == BEATS - 1);
      beat_log.push_back('{data: bus.o_u2a_wdata, last: bus.o_u2a_wlast});
      beat_idx = (beat_idx + 1) % BEATS;
      beats_since_cmd++;
    end
    if (bus.o_u2a_valid && !bus.i_axi_ready) cmd_stalls++;
    if (bus.o_u2a_valid && bus.i_axi_ready) begin
      check("cmd_addr", bus.o_u2a_addr, m_addr[31:0]);
      check("cmd_len", bus.o_u2a_length, BEATS - 1);
      check("cmd_after_beats", beats_since_cmd, BEATS);
      cmd_log.push_back('{addr: bus.o_u2a_addr, len: bus.o_u2a_length, stalls: cmd_stalls});
      cmd_stalls = 0;
      m_addr = (m_addr + LEN > m_faddr) ? m_baddr : m_addr + LEN;
      beats_since_cmd = 0;
      words_in_burst  = 0;
    end
  endtask

  initial begin
    mon_en = 0;
    forever begin
      @(negedge clk); #1;
      if (mon_en) monitor_cycle();
    end
  end

  // ---------------- sink-side ready drivers ----------------
  int wr_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int cmd_mode = 0;  // 0: always ready, 1: random, 2: hold 20 cycles per command
  int hold_cnt = 0;

  initial begin
    bus.i_axi_wready = 1'b1;
    bus.i_axi_ready  = 1'b1;
    forever begin
      @(negedge clk);
      case (wr_mode)
        0:       bus.i_axi_wready = 1'b1;
        1:       bus.i_axi_wready = ~bus.i_axi_wready;
        default: bus.i_axi_wready = 1'($urandom_range(0, 1));
      endcase
      case (cmd_mode)
        0: bus.i_axi_ready = 1'b1;
        1: bus.i_axi_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.o_u2a_valid) hold_cnt++; else hold_cnt = 0;
          bus.i_axi_ready = (hold_cnt > 20);
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [UW-1:0] w, input int gap);
    int n;
    repeat (gap) begin @(negedge clk); bus.i_user_valid = 1'b0; end
    @(negedge clk);
    bus.i_user_data  = w;
    bus.i_user_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.o_user_ready && n < BOUND) begin @(negedge clk); #1; n++; end
    if (n >= BOUND) check("send_word_ready", bus.o_user_ready, 1);
    else @(posedge clk);
  endtask

  task automatic stream(input int n, input bit rnd, input int max_gap, input logic [UW-1:0] base);
    for (int i = 0; i < n; i++)
      send_word(rnd ? UW'($urandom) : base + UW'(i), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    @(negedge clk);
    bus.i_user_valid = 1'b0;
  endtask

  task automatic wait_cmds(input int n);
    int k = 0;
    while (cmd_log.size() < n && k < BOUND) begin @(negedge clk); k++; end
    check("cmd_count", cmd_log.size(), n);
  endtask

  task automatic do_reset(input logic [31:0] b, input logic [31:0] f);
    mon_en = 0;
    @(negedge clk);
    bus.i_user_valid = 1'b0;
    baddr = b; faddr = f; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sb_clear(b, f);
    mon_en = 1;
  endtask

  function automatic wrap_vec_t mk_vec(input logic [31:0] b, input logic [31:0] f,
                                       input logic [31:0] a0, input logic [31:0] a1,
                                       input logic [31:0] a2, input logic [31:0] a3);
    wrap_vec_t v;
    v.baddr = b; v.faddr = f;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  wrap_vec_t vecs[4];
  int seen, rise;

  initial begin
    vecs[0] = mk_vec(32'h0000_0000, 32'h0000_00BF, 32'h00, 32'h40, 32'h80, 32'h00);
    vecs[1] = mk_vec(32'h0000_1000, 32'h0000_107F, 32'h1000, 32'h1040, 32'h1000, 32'h1040);
    vecs[2] = mk_vec(32'h0000_0200, 32'h0000_023F, 32'h200, 32'h200, 32'h200, 32'h200);
    vecs[3] = mk_vec(32'hFFFF_FF80, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'hFFFF_FFC0,
                     32'hFFFF_FF80, 32'hFFFF_FFC0);

    rst = 1'b1; ddr_init = 1'b0; baddr = 32'h0000_1000; faddr = 32'h0000_FFFF;
    bus.i_user_valid = 1'b0; bus.i_user_data = '0;

    // Reset values, observed while reset is held
    repeat (4) @(negedge clk);
    check("rst_wvalid", bus.o_u2a_wvalid, 0);
    check("rst_wlast", bus.o_u2a_wlast, 0);
    check("rst_cmd_valid", bus.o_u2a_valid, 0);
    check("rst_user_ready", bus.o_user_ready, 0);
    check("rst_wdata", bus.o_u2a_wdata, 0);
    check("rst_addr", bus.o_u2a_addr, baddr);
    check("length", bus.o_u2a_length, BEATS - 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sb_clear(baddr, faddr);
    mon_en = 1;

    // Bring-up gating
    bus.i_user_valid = 1'b1;
    seen = 0;
    repeat (50) begin @(negedge clk); #1; if (bus.o_user_ready) seen++; end
    check("gate_ready_low", seen, 0);
    @(negedge clk);
    bus.i_user_valid = 1'b0;
    ddr_init = 1'b1;
    rise = 0;
    for (int i = 1; i <= 6 && rise == 0; i++) begin
      @(posedge clk); #1;
      if (bus.o_user_ready) rise = i;
    end
    check("init_ready_by_4th", (rise >= 1 && rise <= 4), 1);

    // Reduced-config burst with incrementing words
    stream(WPB, 1'b0, 0, 16'h0000);
    wait_cmds(1);
    check("burst_beat_count", beat_log.size(), BEATS);
    if (beat_log.size() == BEATS) begin
      check("first_beat", beat_log[0].data, 128'h0000_0001_0002_0003_0004_0005_0006_0007);
      for (int k = 0; k < BEATS; k++) check("wlast_position", beat_log[k].last, k == BEATS - 1);
    end
    if (cmd_log.size() >= 1) begin
      check("first_cmd_addr", cmd_log[0].addr, baddr);
      check("first_cmd_len", cmd_log[0].len, 3);
    end

    // Address wrap table
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].baddr, vecs[v].faddr);
      stream(4 * WPB, 1'b1, 0, '0);
      wait_cmds(4);
      for (int k = 0; k < 4 && k < cmd_log.size(); k++)
        check($sformatf("wrap_v%0d_cmd%0d", v, k), cmd_log[k].addr, vecs[v].exp_addr[k]);
    end

    // Backpressure: toggling wready, command held off 20 cycles
    do_reset(32'h0000_2000, 32'h0000_FFFF);
    wr_mode = 1; cmd_mode = 2;
    stream(2 * WPB, 1'b1, 0, '0);
    wait_cmds(2);
    for (int k = 0; k < 2 && k < cmd_log.size(); k++) check("cmd_hold_cycles", cmd_log[k].stalls, 20);
    check("bp_words_consumed", word_q.size(), 0);

    // Randomised traffic across a wrap
    wr_mode = 2; cmd_mode = 1;
    do_reset(32'h0000_0000, 32'h0000_013F);
    stream(6 * WPB, 1'b1, 2, '0);
    wait_cmds(6);
    check("rand_words_consumed", word_q.size(), 0);
    wr_mode = 0; cmd_mode = 0;

    // Reset in the middle of a burst
    do_reset(32'h0000_0100, 32'h0000_0FFF);
    stream(WPB, 1'b1, 0, '0);
    wait_cmds(1);
    stream(2 * PACK, 1'b1, 0, '0);
    repeat (3) @(negedge clk);
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_wvalid", bus.o_u2a_wvalid, 0);
    check("mid_rst_wlast", bus.o_u2a_wlast, 0);
    check("mid_rst_cmd_valid", bus.o_u2a_valid, 0);
    check("mid_rst_user_ready", bus.o_user_ready, 0);
    check("mid_rst_wdata", bus.o_u2a_wdata, 0);
    check("mid_rst_addr", bus.o_u2a_addr, 32'h0000_0100);
    repeat (2) @(negedge clk);
    sb_clear(32'h0000_0100, 32'h0000_0FFF);
    mon_en = 1;
    stream(WPB, 1'b1, 0, '0);
    wait_cmds(1);
    repeat (50) @(negedge clk);
    check("post_rst_one_cmd", cmd_log.size(), 1);
    if (cmd_log.size() >= 1) check("post_rst_cmd_addr", cmd_log[0].addr, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
